// File: rtl/answer_collector.sv
// Answer-entry FSM for a grid memory game: the player steers a cursor, toggles cells, submits.
// Optional build macro ANSWER_TIMEOUT_EN adds an ENTRY-phase timeout (TIMEOUT_CYCLES).
module answer_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        start,
  input  logic [1:0]  level,
  input  logic [24:0] target,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_toggle,
  input  logic        btn_submit,
  output logic [24:0] grid,
  output logic [2:0]  cur_row,
  output logic [2:0]  cur_col,
  output logic        done,
  output logic        ans,
  output logic        timed_out,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ENTRY  = 2'b01,
    ST_CHECK  = 2'b10,
    ST_RESULT = 2'b11
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_n, w_n_nxt;
  logic [24:0] r_target, w_target_nxt;
  logic [24:0] r_grid, w_grid_nxt;
  logic [2:0]  r_row, w_row_nxt;
  logic [2:0]  r_col, w_col_nxt;
  logic        r_ans, w_ans_nxt;

  logic [2:0]  w_level_n;
  logic [24:0] w_level_mask;
  logic [24:0] w_mask;
  logic [4:0]  w_idx;
  logic        w_match;
  logic        w_timed_out_cur;

`ifdef ANSWER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic             r_timed_out, w_timed_out_nxt;
  logic             w_expire;

  // The cycle holding the last remaining count is the final ENTRY cycle.
  assign w_expire        = (r_timer <= TMR_W'(1));
  assign w_timed_out_cur = r_timed_out;
`else
  assign w_timed_out_cur = 1'b0;
`endif

  always_comb begin
    w_level_n = 3'd3;
    case (level)
      2'b10:   w_level_n = 3'd4;
      2'b11:   w_level_n = 3'd5;
      default: w_level_n = 3'd3;
    endcase
  end

  always_comb begin
    w_level_mask = 25'h00001FF;
    case (w_level_n)
      3'd4:    w_level_mask = 25'h000FFFF;
      3'd5:    w_level_mask = 25'h1FFFFFF;
      default: w_level_mask = 25'h00001FF;
    endcase
  end

  always_comb begin
    w_mask = 25'h00001FF;
    case (r_n)
      3'd4:    w_mask = 25'h000FFFF;
      3'd5:    w_mask = 25'h1FFFFFF;
      default: w_mask = 25'h00001FF;
    endcase
  end

  assign w_idx   = 5'(r_row) * 5'(r_n) + 5'(r_col);
  assign w_match = (((r_grid ^ r_target) & w_mask) == 25'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_n      <= 3'd3;
      r_target <= '0;
      r_grid   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_ans    <= 1'b0;
`ifdef ANSWER_TIMEOUT_EN
      r_timer     <= TMR_LOAD;
      r_timed_out <= 1'b0;
`endif
    end else if (en) begin
      r_state  <= w_state_nxt;
      r_n      <= w_n_nxt;
      r_target <= w_target_nxt;
      r_grid   <= w_grid_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_ans    <= w_ans_nxt;
`ifdef ANSWER_TIMEOUT_EN
      r_timer     <= w_timer_nxt;
      r_timed_out <= w_timed_out_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_n_nxt      = r_n;
    w_target_nxt = r_target;
    w_grid_nxt   = r_grid;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_ans_nxt    = r_ans;
`ifdef ANSWER_TIMEOUT_EN
    w_timer_nxt     = r_timer;
    w_timed_out_nxt = r_timed_out;
`endif

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_ENTRY;
          w_n_nxt      = w_level_n;
          w_target_nxt = target & w_level_mask;
          w_grid_nxt   = '0;
          w_row_nxt    = '0;
          w_col_nxt    = '0;
          w_ans_nxt    = 1'b0;
`ifdef ANSWER_TIMEOUT_EN
          w_timer_nxt     = TMR_LOAD;
          w_timed_out_nxt = 1'b0;
`endif
        end
      end

      ST_ENTRY: begin
        // One action per cycle, highest-priority button wins.
        if (btn_submit) begin
          w_state_nxt = ST_CHECK;
        end else if (btn_toggle) begin
          w_grid_nxt = (r_grid ^ (25'd1 << w_idx)) & w_mask;
        end else if (btn_up) begin
          w_row_nxt = (r_row == 3'd0) ? (r_n - 3'd1) : (r_row - 3'd1);
        end else if (btn_down) begin
          w_row_nxt = (r_row == (r_n - 3'd1)) ? 3'd0 : (r_row + 3'd1);
        end else if (btn_left) begin
          w_col_nxt = (r_col == 3'd0) ? (r_n - 3'd1) : (r_col - 3'd1);
        end else if (btn_right) begin
          w_col_nxt = (r_col == (r_n - 3'd1)) ? 3'd0 : (r_col + 3'd1);
        end
`ifdef ANSWER_TIMEOUT_EN
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
        if (w_expire && !btn_submit) begin
          w_state_nxt     = ST_CHECK;
          w_timed_out_nxt = 1'b1;
        end
`endif
      end

      ST_CHECK: begin
        w_ans_nxt   = w_match & ~w_timed_out_cur;
        w_state_nxt = ST_RESULT;
      end

      ST_RESULT: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pulse is qualified by en so a frozen RESULT state still yields a single done cycle.
  assign done      = (r_state == ST_RESULT) && en;
  assign grid      = r_grid;
  assign cur_row   = r_row;
  assign cur_col   = r_col;
  assign ans       = r_ans;
  assign timed_out = w_timed_out_cur;
  assign o_state   = r_state;

endmodule

// File: tb/tb_answer_collector.sv
// Directed self-checking bench for answer_collector; expectations are hand-computed.
// Covers navigation, toggling, priority, compare, reset, enable freeze and the timeout option.
module tb_answer_collector;

  logic        clk = 1'b0;
  logic        reset, en, start;
  logic [1:0]  level;
  logic [24:0] target;
  logic        btn_up, btn_down, btn_left, btn_right, btn_toggle, btn_submit;
  logic [24:0] grid;
  logic [2:0]  cur_row, cur_col;
  logic        done, ans, timed_out;
  logic [1:0]  o_state;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] B_SUB = 6'b100000;
  localparam logic [5:0] B_TOG = 6'b010000;
  localparam logic [5:0] B_UP  = 6'b001000;
  localparam logic [5:0] B_DN  = 6'b000100;
  localparam logic [5:0] B_LT  = 6'b000010;
  localparam logic [5:0] B_RT  = 6'b000001;

  answer_collector #(.TIMEOUT_CYCLES(30)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .level(level), .target(target),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_toggle(btn_toggle), .btn_submit(btn_submit),
    .grid(grid), .cur_row(cur_row), .cur_col(cur_col), .done(done), .ans(ans),
    .timed_out(timed_out), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [5:0] b);
    {btn_submit, btn_toggle, btn_up, btn_down, btn_left, btn_right} = b;
    step();
    {btn_submit, btn_toggle, btn_up, btn_down, btn_left, btn_right} = 6'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; en = 1'b1; start = 1'b0; level = 2'b00; target = '0;
    {btn_submit, btn_toggle, btn_up, btn_down, btn_left, btn_right} = 6'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_state", 32'(o_state), 32'h0);
    chk("rst_grid", 32'(grid), 32'h0);
    chk("rst_row", 32'(cur_row), 32'h0);
    chk("rst_col", 32'(cur_col), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ans", 32'(ans), 32'h0);
    chk("rst_to", 32'(timed_out), 32'h0);

    // 3x3 diagonal vs partial target -> wrong answer
    level = 2'b01; target = 25'h011;
    do_start();
    chk("r1_entry", 32'(o_state), 32'h1);
    press(B_TOG);
    chk("r1_tog00", 32'(grid), 32'h001);
    press(B_RT); press(B_DN); press(B_TOG);
    chk("r1_tog11", 32'(grid), 32'h011);
    press(B_DN); press(B_RT); press(B_TOG);
    chk("r1_grid", 32'(grid), 32'h111);
    chk("r1_row", 32'(cur_row), 32'h2);
    chk("r1_col", 32'(cur_col), 32'h2);
    press(B_SUB);
    chk("r1_check", 32'(o_state), 32'h2);
    chk("r1_nodone", 32'(done), 32'h0);
    step();
    chk("r1_result", 32'(o_state), 32'h3);
    chk("r1_done", 32'(done), 32'h1);
    chk("r1_ans", 32'(ans), 32'h0);
    step();
    chk("r1_idle", 32'(o_state), 32'h0);
    chk("r1_done_off", 32'(done), 32'h0);

    // 5x5 corner cell; level change mid-round must not alter N
    level = 2'b11; target = 25'h1000000;
    do_start();
    level = 2'b00;
    repeat (4) press(B_DN);
    repeat (4) press(B_RT);
    chk("r2_row", 32'(cur_row), 32'h4);
    chk("r2_col", 32'(cur_col), 32'h4);
    press(B_TOG);
    chk("r2_grid", 32'(grid), 32'h1000000);
    press(B_SUB);
    step();
    chk("r2_done", 32'(done), 32'h1);
    chk("r2_ans", 32'(ans), 32'h1);
    step();
    chk("r2_done_off", 32'(done), 32'h0);
    chk("r2_ans_held", 32'(ans), 32'h1);

    // 4x4 wrap-around, priority, start ignored in ENTRY
    level = 2'b10; target = 25'h0;
    do_start();
    chk("r3_ans_clr", 32'(ans), 32'h0);
    repeat (3) press(B_RT);
    chk("r3_col3", 32'(cur_col), 32'h3);
    press(B_RT);
    chk("r3_colwrap", 32'(cur_col), 32'h0);
    press(B_UP);
    chk("r3_rowwrap", 32'(cur_row), 32'h3);
    press(B_TOG | B_RT);
    chk("r3_pri_grid", 32'(grid), 32'h1000);
    chk("r3_pri_col", 32'(cur_col), 32'h0);
    press(B_UP | B_DN | B_LT);
    chk("r3_up_pri", 32'(cur_row), 32'h2);
    chk("r3_up_pri_col", 32'(cur_col), 32'h0);
    do_start();
    chk("r3_start_ign", 32'(o_state), 32'h1);
    chk("r3_start_grid", 32'(grid), 32'h1000);
    press(B_SUB | B_TOG);
    chk("r3_sub_pri", 32'(o_state), 32'h2);
    chk("r3_sub_grid", 32'(grid), 32'h1000);
    step();
    chk("r3_ans", 32'(ans), 32'h0);
    step();
    press(B_TOG | B_DN);
    chk("r3_idle_btn_grid", 32'(grid), 32'h1000);
    chk("r3_idle_btn_row", 32'(cur_row), 32'h2);

    // en=0 freezes IDLE against start
    en = 1'b0;
    do_start();
    chk("en0_idle", 32'(o_state), 32'h0);
    en = 1'b1;

    // build grid 0x1F on 3x3, freeze with en=0, then reset mid-round
    level = 2'b01; target = 25'h1F;
    do_start();
    press(B_TOG); press(B_RT); press(B_TOG); press(B_RT); press(B_TOG);
    press(B_DN); press(B_RT); press(B_TOG); press(B_RT); press(B_TOG);
    chk("r4_grid", 32'(grid), 32'h1F);
    en = 1'b0;
    press(B_TOG);
    chk("r4_en0_grid", 32'(grid), 32'h1F);
    reset = 1'b1;
    step();
    reset = 1'b0;
    en = 1'b1;
    chk("r4_rst_state", 32'(o_state), 32'h0);
    chk("r4_rst_grid", 32'(grid), 32'h0);
    chk("r4_rst_ans", 32'(ans), 32'h0);
    chk("r4_rst_col", 32'(cur_col), 32'h0);

`ifdef ANSWER_TIMEOUT_EN
    level = 2'b00; target = 25'h0;
    do_start();
    repeat (29) step();
    chk("to_still_entry", 32'(o_state), 32'h1);
    step();
    chk("to_check", 32'(o_state), 32'h2);
    chk("to_flag", 32'(timed_out), 32'h1);
    step();
    chk("to_done", 32'(done), 32'h1);
    chk("to_ans", 32'(ans), 32'h0);
    step();
    do_start();
    chk("to_flag_clr", 32'(timed_out), 32'h0);
    repeat (29) step();
    press(B_SUB);
    chk("sub_win_state", 32'(o_state), 32'h2);
    chk("sub_win_flag", 32'(timed_out), 32'h0);
    step();
    chk("sub_win_ans", 32'(ans), 32'h1);
    step();
`else
    level = 2'b00; target = 25'h0;
    do_start();
    repeat (40) step();
    chk("noto_entry", 32'(o_state), 32'h1);
    chk("noto_flag", 32'(timed_out), 32'h0);
    press(B_SUB);
    step();
    chk("noto_ans", 32'(ans), 32'h1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
